ps2_key_decoder: RTL and testbench

- Keyboard-side producer of the 8-bit `key` bus consumed by the game control FSM.
- Samples the raw PS/2 clock/data lines and deframes 11-bit device-to-host frames.
- Decodes make/break (F0) and extended (E0) prefixes.
- Presents the currently held scancode, plus one-cycle press/release strobes.

---
 rtl/ps2_key_decoder.sv | 250 +++++++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronises the raw PS/2 lines, deframes the
// 11-bit device-to-host frames and tracks the held key, including the E0
// (extended) and F0 (break) prefixes. All outputs are registered.
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TIMER_W        = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] key,
  output logic       key_ext,
  output logic       key_press,
  output logic       key_release,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frameState_t;

  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  // Odd parity over data plus parity bit: the frame is consistent when the
  // total number of ones is odd.
  function automatic logic oddParityOk(input logic [7:0] data, input logic par);
    return (^data) ^ par;
  endfunction

  logic [1:0]         clkSync_r;
  logic [1:0]         datSync_r;
  logic               clkPrev_r;
  logic               fe_s;
  logic               datBit_s;

  frameState_t        state_r;
  frameState_t        nextState_s;
  logic [2:0]         bitCnt_r;
  logic [2:0]         nextBitCnt_s;
  logic [7:0]         shift_r;
  logic [7:0]         nextShift_s;
  logic               parity_r;
  logic               nextParity_s;
  logic [TIMER_W-1:0] timer_r;
  logic               timeout_s;
  logic               frameDone_s;
  logic               frameGood_s;

  logic [7:0]         key_r;
  logic [7:0]         nextKey_s;
  logic               keyExt_r;
  logic               nextKeyExt_s;
  logic               extFlag_r;
  logic               nextExtFlag_s;
  logic               brkFlag_r;
  logic               nextBrkFlag_s;
  logic [7:0]         rxByte_r;
  logic [7:0]         nextRxByte_s;
  logic               press_r;
  logic               press_s;
  logic               release_r;
  logic               release_s;
  logic               valid_r;
  logic               valid_s;
  logic               err_r;
  logic               err_s;

  // Two-flop synchronisers for the asynchronous PS/2 lines; idle-high preset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clkSync_r <= 2'b11;
      datSync_r <= 2'b11;
      clkPrev_r <= 1'b1;
    end else begin
      clkSync_r <= {clkSync_r[0], ps2_clk};
      datSync_r <= {datSync_r[0], ps2_dat};
      clkPrev_r <= clkSync_r[1];
    end
  end

  assign fe_s     = clkPrev_r & ~clkSync_r[1];
  assign datBit_s = datSync_r[1];

  // Frame deserialiser state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      bitCnt_r <= 3'd0;
      shift_r  <= 8'h00;
      parity_r <= 1'b0;
    end else begin
      state_r  <= nextState_s;
      bitCnt_r <= nextBitCnt_s;
      shift_r  <= nextShift_s;
      parity_r <= nextParity_s;
    end
  end

  // Inter-edge watchdog: restarts on every falling edge and only runs while
  // a frame is in progress, so an abandoned frame falls back to IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer_r <= '0;
    end else if (fe_s) begin
      timer_r <= '0;
    end else if ((state_r != IDLE) && !timeout_s) begin
      timer_r <= timer_r + {{(TIMER_W-1){1'b0}}, 1'b1};
    end else begin
      timer_r <= '0;
    end
  end

  assign timeout_s = (state_r != IDLE) && (timer_r == TIMEOUT_LAST);

  // Frame next-state logic; advances only on a PS/2 falling edge.
  always_comb begin
    nextState_s  = state_r;
    nextBitCnt_s = bitCnt_r;
    nextShift_s  = shift_r;
    nextParity_s = parity_r;
    frameDone_s  = 1'b0;
    frameGood_s  = 1'b0;
    if (fe_s) begin
      case (state_r)
        IDLE: begin
          if (!datBit_s) begin
            nextState_s  = DATA;
            nextBitCnt_s = 3'd0;
          end else begin
            nextState_s = IDLE;
          end
        end
        DATA: begin
          nextShift_s[bitCnt_r] = datBit_s;
          if (bitCnt_r == 3'd7) begin
            nextState_s = PARITY;
          end else begin
            nextBitCnt_s = bitCnt_r + 3'd1;
          end
        end
        PARITY: begin
          nextParity_s = datBit_s;
          nextState_s  = STOP;
        end
        STOP: begin
          frameDone_s = 1'b1;
          frameGood_s = datBit_s & oddParityOk(shift_r, parity_r);
          nextState_s = IDLE;
        end
        default: begin
          nextState_s = IDLE;
        end
      endcase
    end else if (timeout_s) begin
      nextState_s = IDLE;
    end else begin
      nextState_s = state_r;
    end
  end

  // Byte decode: prefix tracking and held-key update for completed frames.
  always_comb begin
    nextKey_s     = key_r;
    nextKeyExt_s  = keyExt_r;
    nextExtFlag_s = extFlag_r;
    nextBrkFlag_s = brkFlag_r;
    nextRxByte_s  = rxByte_r;
    press_s       = 1'b0;
    release_s     = 1'b0;
    valid_s       = 1'b0;
    err_s         = 1'b0;
    if (frameDone_s) begin
      if (frameGood_s) begin
        valid_s      = 1'b1;
        nextRxByte_s = shift_r;
        if (shift_r == 8'hE0) begin
          nextExtFlag_s = 1'b1;
        end else if (shift_r == 8'hF0) begin
          nextBrkFlag_s = 1'b1;
        end else begin
          nextExtFlag_s = 1'b0;
          nextBrkFlag_s = 1'b0;
          if (brkFlag_r) begin
            // Only the break of the key actually held releases it.
            if ((shift_r == key_r) && (extFlag_r == keyExt_r) && (key_r != 8'h00)) begin
              nextKey_s    = 8'h00;
              nextKeyExt_s = 1'b0;
              release_s    = 1'b1;
            end else begin
              nextKey_s = key_r;
            end
          end else begin
            // Typematic repeat of the held key leaves key unchanged, no strobe.
            if (((shift_r != key_r) || (extFlag_r != keyExt_r)) && (shift_r != 8'h00)) begin
              nextKey_s    = shift_r;
              nextKeyExt_s = extFlag_r;
              press_s      = 1'b1;
            end else begin
              nextKey_s = key_r;
            end
          end
        end
      end else begin
        err_s = 1'b1;
      end
    end else begin
      nextKey_s = key_r;
    end
  end

  // Registered decoder state and one-cycle output strobes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_r     <= 8'h00;
      keyExt_r  <= 1'b0;
      extFlag_r <= 1'b0;
      brkFlag_r <= 1'b0;
      rxByte_r  <= 8'h00;
      press_r   <= 1'b0;
      release_r <= 1'b0;
      valid_r   <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      key_r     <= nextKey_s;
      keyExt_r  <= nextKeyExt_s;
      extFlag_r <= nextExtFlag_s;
      brkFlag_r <= nextBrkFlag_s;
      rxByte_r  <= nextRxByte_s;
      press_r   <= press_s;
      release_r <= release_s;
      valid_r   <= valid_s;
      err_r     <= err_s;
    end
  end

  assign key         = key_r;
  assign key_ext     = keyExt_r;
  assign key_press   = press_r;
  assign key_release = release_r;
  assign rx_byte     = rxByte_r;
  assign rx_valid    = valid_r;
  assign frame_err   = err_r;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: a table of frames with expected held
// key, raw byte and strobe counts, plus hand-written timeout and reset cases.
module tb_ps2_key_decoder;

  localparam int TO_CYCLES = 200;
  localparam int HALF      = 20;   // PS/2 half period in system clocks

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ps2Clk = 1'b1;
  logic       ps2Dat = 1'b1;
  logic [7:0] key;
  logic       keyExt;
  logic       keyPress;
  logic       keyRelease;
  logic [7:0] rxByte;
  logic       rxValid;
  logic       frameErr;

  int nCompared = 0;
  int nMismatched = 0;
  int pressCnt = 0, relCnt = 0, validCnt = 0, errCnt = 0, bothCnt = 0;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TO_CYCLES), .TIMER_W(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .ps2_clk    (ps2Clk),
    .ps2_dat    (ps2Dat),
    .key        (key),
    .key_ext    (keyExt),
    .key_press  (keyPress),
    .key_release(keyRelease),
    .rx_byte    (rxByte),
    .rx_valid   (rxValid),
    .frame_err  (frameErr)
  );

  always #5 clock = ~clock;

  // Strobe counters sampled on the inactive edge; a strobe held two cycles
  // counts twice.
  always @(negedge clock) begin
    if (keyPress)   pressCnt++;
    if (keyRelease) relCnt++;
    if (rxValid)    validCnt++;
    if (frameErr)   errCnt++;
    if (keyPress && keyRelease) bothCnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] data;
    logic [1:0] kind;     // 0 good, 1 bad parity, 2 bad stop bit
    logic [7:0] expKey;
    logic       expExt;
    logic [7:0] expRx;
    logic [1:0] expPress;
    logic [1:0] expRel;
    logic [1:0] expValid;
    logic [1:0] expErr;
  } vec_t;

  vec_t vecs[25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Send the first nbits of an 11-bit frame (start, data LSB first, parity, stop).
  task automatic sendBits(input logic [7:0] data, input logic [1:0] kind, input int nbits);
    logic [10:0] frame;
    logic        par;
    logic        stp;
    par   = ~(^data) ^ (kind == 2'd1);
    stp   = (kind == 2'd2) ? 1'b0 : 1'b1;
    frame = {stp, par, data, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2Dat = frame[i];
      repeat (HALF) @(posedge clock);
      #2 ps2Clk = 1'b0;
      repeat (HALF) @(posedge clock);
      #2 ps2Clk = 1'b1;
    end
  endtask

  task automatic frameAndCheck(input string tag, input logic [7:0] data, input logic [1:0] kind,
                               input logic [7:0] eKey, input logic eExt, input logic [7:0] eRx,
                               input int ePress, input int eRel, input int eValid, input int eErr);
    int p0, r0, v0, e0;
    p0 = pressCnt; r0 = relCnt; v0 = validCnt; e0 = errCnt;
    sendBits(data, kind, 11);
    ps2Dat = 1'b1;
    repeat (2 * HALF) @(posedge clock);
    #1;
    check({tag, " key"},     32'(key),    32'(eKey));
    check({tag, " key_ext"}, 32'(keyExt), 32'(eExt));
    check({tag, " rx_byte"}, 32'(rxByte), 32'(eRx));
    check({tag, " press"},   32'(pressCnt - p0), 32'(ePress));
    check({tag, " release"}, 32'(relCnt - r0),   32'(eRel));
    check({tag, " valid"},   32'(validCnt - v0), 32'(eValid));
    check({tag, " err"},     32'(errCnt - e0),   32'(eErr));
  endtask

  initial begin
    int p0, r0, v0, e0;
    //          data   kind  key    ext   rx     prs   rel   val   err
    vecs[0]  = '{8'h1C, 2'd0, 8'h1C, 1'b0, 8'h1C, 2'd1, 2'd0, 2'd1, 2'd0};
    vecs[1]  = '{8'hF0, 2'd0, 8'h1C, 1'b0, 8'hF0, 2'd0, 2'd0, 2'd1, 2'd0};
    vecs[2]  = '{8'h1C, 2'd0, 8'h00, 1'b0, 8'h1C, 2'd0, 2'd1, 2'd1, 2'd0};
    vecs[3]  = '{8'h1C, 2'd1, 8'h00, 1'b0, 8'h1C, 2'd0, 2'd0, 2'd0, 2'd1};
    vecs[4]  = '{8'h29, 2'd0, 8'h29, 1'b0, 8'h29, 2'd1, 2'd0, 2'd1, 2'd0};
    vecs[5]  = '{8'hE0, 2'd0, 8'h29, 1'b0, 8'hE0, 2'd0, 2'd0, 2'd1, 2'd0};
    vecs[6]  = '{8'h75, 2'd0, 8'h75, 1'b1, 8'h75, 2'd1, 2'd0, 2'd1, 2'd0};
    vecs[7]  = '{8'hE0, 2'd0, 8'h75, 1'b1, 8'hE0, 2'd0, 2'd0, 2'd1, 2'd0};
    vecs[8]  = '{8'h75, 2'd0, 8'h75, 1'b1, 8'h75, 2'd0, 2'd0, 2'd1, 2'd0};
    vecs[9]  = '{8'hE0, 2'd0, 8'h75, 1'b1, 8'hE0, 2'd0, 2'd0, 2'd1, 2'd0};
    vecs[10] = '{8'hF0, 2'd0, 8'h75, 1'b1, 8'hF0, 2'd0, 2'd0, 2'd1, 2'd0};
    vecs[11] = '{8'h75, 2'd0, 8'h00, 1'b0, 8'h75, 2'd0, 2'd1, 2'd1, 2'd0};
    vecs[12] = '{8'h1C, 2'd0, 8'h1C, 1'b0, 8'h1C, 2'd1, 2'd0, 2'd1, 2'd0};
    vecs[13] = '{8'h29, 2'd0, 8'h29, 1'b0, 8'h29, 2'd1, 2'd0, 2'd1, 2'd0};
    vecs[14] = '{8'hF0, 2'd0, 8'h29, 1'b0, 8'hF0, 2'd0, 2'd0, 2'd1, 2'd0};
    vecs[15] = '{8'h1C, 2'd0, 8'h29, 1'b0, 8'h1C, 2'd0, 2'd0, 2'd1, 2'd0};
    vecs[16] = '{8'hF0, 2'd0, 8'h29, 1'b0, 8'hF0, 2'd0, 2'd0, 2'd1, 2'd0};
    vecs[17] = '{8'h29, 2'd0, 8'h00, 1'b0, 8'h29, 2'd0, 2'd1, 2'd1, 2'd0};
    vecs[18] = '{8'h1C, 2'd2, 8'h00, 1'b0, 8'h29, 2'd0, 2'd0, 2'd0, 2'd1};
    vecs[19] = '{8'h75, 2'd0, 8'h75, 1'b0, 8'h75, 2'd1, 2'd0, 2'd1, 2'd0};
    vecs[20] = '{8'hE0, 2'd0, 8'h75, 1'b0, 8'hE0, 2'd0, 2'd0, 2'd1, 2'd0};
    vecs[21] = '{8'hF0, 2'd0, 8'h75, 1'b0, 8'hF0, 2'd0, 2'd0, 2'd1, 2'd0};
    vecs[22] = '{8'h75, 2'd0, 8'h75, 1'b0, 8'h75, 2'd0, 2'd0, 2'd1, 2'd0};
    vecs[23] = '{8'hF0, 2'd0, 8'h75, 1'b0, 8'hF0, 2'd0, 2'd0, 2'd1, 2'd0};
    vecs[24] = '{8'h75, 2'd0, 8'h00, 1'b0, 8'h75, 2'd0, 2'd1, 2'd1, 2'd0};

    // Reset state
    #1;
    check("reset key",     32'(key),        32'h0);
    check("reset key_ext", 32'(keyExt),     32'h0);
    check("reset rx_byte", 32'(rxByte),     32'h0);
    check("reset strobes", 32'({keyPress, keyRelease, rxValid, frameErr}), 32'h0);
    repeat (5) @(posedge clock);
    #2 reset = 1'b1;
    repeat (5) @(posedge clock);

    for (int i = 0; i < 25; i++) begin
      frameAndCheck($sformatf("vec%0d", i), vecs[i].data, vecs[i].kind,
                    vecs[i].expKey, vecs[i].expExt, vecs[i].expRx,
                    int'(vecs[i].expPress), int'(vecs[i].expRel),
                    int'(vecs[i].expValid), int'(vecs[i].expErr));
    end

    // Timeout: start bit plus 4 data bits, then the line idles.
    p0 = pressCnt; r0 = relCnt; v0 = validCnt; e0 = errCnt;
    sendBits(8'h5A, 2'd0, 5);
    ps2Dat = 1'b1;
    repeat (TO_CYCLES + 10) @(posedge clock);
    #1;
    check("timeout press",   32'(pressCnt - p0), 32'd0);
    check("timeout release", 32'(relCnt - r0),   32'd0);
    check("timeout valid",   32'(validCnt - v0), 32'd0);
    check("timeout err",     32'(errCnt - e0),   32'd0);
    check("timeout key",     32'(key),           32'h0);
    frameAndCheck("after timeout", 8'h29, 2'd0, 8'h29, 1'b0, 8'h29, 1, 0, 1, 0);

    // Asynchronous reset during data bit 5 of a frame.
    sendBits(8'h1C, 2'd0, 6);
    ps2Dat = 1'b0;  // bit 5 of 0x1C
    repeat (5) @(posedge clock);
    #3 reset = 1'b0;
    #1;
    check("async reset key",     32'(key),    32'h0);
    check("async reset key_ext", 32'(keyExt), 32'h0);
    check("async reset rx_byte", 32'(rxByte), 32'h0);
    check("async reset strobes", 32'({keyPress, keyRelease, rxValid, frameErr}), 32'h0);
    ps2Dat = 1'b1;
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    repeat (5) @(posedge clock);
    frameAndCheck("after reset", 8'h1C, 2'd0, 8'h1C, 1'b0, 8'h1C, 1, 0, 1, 0);

    check("press and release together", 32'(bothCnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
